// File: rtl/temporal_pulse_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stc_pkg
// Purpose  : Shared types and constants for the temporal pulse encoder.
// Revision : 1.0 - initial release
// ============================================================================
package stc_pkg;

   localparam int DEF_GAMMA_CYCLE_WIDTH = 16;
   localparam int DEF_PULSE_WIDTH       = 8;
   localparam int DEF_NUM_LANES         = 4;
   localparam int VAL_W                 = $clog2(DEF_GAMMA_CYCLE_WIDTH) + 1;

   typedef logic [VAL_W-1:0] time_t;

   localparam time_t TIME_INF = {1'b1, {(VAL_W-1){1'b0}}};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic is_inf(input time_t t);
      return t[VAL_W-1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/temporal_pulse_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : temporal_pulse_encoder_if
// Purpose  : Vector handshake and temporal output bundle of the pulse encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface temporal_pulse_encoder_if #(
   parameter int NUM_LANES = 4,
   parameter int VAL_W     = 5
) ();

   logic                       in_valid;
   logic                       in_ready;
   logic [NUM_LANES*VAL_W-1:0] in_times;
   logic [NUM_LANES-1:0]       q;
   logic                       gamma_start;
   logic                       gamma_done;
   logic                       busy;

   modport master (
      output in_valid, in_times,
      input  in_ready, q, gamma_start, gamma_done, busy
   );

   modport slave (
      input  in_valid, in_times,
      output in_ready, q, gamma_start, gamma_done, busy
   );

endinterface
`default_nettype wire

// File: rtl/temporal_lane_pulse.sv
`default_nettype none
// ============================================================================
// Module   : temporal_lane_pulse
// Purpose  : One temporal output wire; high on ticks t..min(t+PW,G)-1 of a gamma.
// Revision : 1.0 - initial release
// ============================================================================
module temporal_lane_pulse #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int VAL_W             = 5,
   parameter int TICK_W            = 4
) (
   input  wire logic              aclk,
   input  wire logic              grst,
   input  wire logic              active_nxt,
   input  wire logic [TICK_W-1:0] tick_nxt,
   input  wire logic [VAL_W-1:0]  t,
   output logic                   q
);

   localparam logic [VAL_W:0] c_GAMMA = (VAL_W+1)'(GAMMA_CYCLE_WIDTH);
   localparam logic [VAL_W:0] c_PW    = (VAL_W+1)'(PULSE_WIDTH);

   logic [VAL_W:0] w_t_ext;
   logic [VAL_W:0] w_tick_ext;
   logic [VAL_W:0] w_end_raw;
   logic [VAL_W:0] w_end;
   logic           w_silent;
   logic           w_hit;
   logic           r_q;

   // One extra bit keeps t+PULSE_WIDTH from wrapping before the clamp.
   assign w_t_ext    = {1'b0, t};
   assign w_tick_ext = {{(VAL_W+1-TICK_W){1'b0}}, tick_nxt};
   assign w_end_raw  = w_t_ext + c_PW;
   assign w_end      = (w_end_raw > c_GAMMA) ? c_GAMMA : w_end_raw;
   assign w_silent   = t[VAL_W-1] || (w_t_ext >= c_GAMMA);
   assign w_hit      = active_nxt && !w_silent &&
                       (w_tick_ext >= w_t_ext) && (w_tick_ext < w_end);

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         r_q <= 1'b0;
      end else begin
         r_q <= w_hit;
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/temporal_pulse_encoder.sv
`default_nettype none
// ============================================================================
// Module   : temporal_pulse_encoder
// Purpose  : Converts binary spike-time vectors into per-lane temporal pulses.
// Revision : 1.0 - initial release
// ============================================================================
module temporal_pulse_encoder
   import stc_pkg::*;
#(
   parameter int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
   parameter int PULSE_WIDTH       = DEF_PULSE_WIDTH,
   parameter int NUM_LANES         = DEF_NUM_LANES
) (
   input wire logic                aclk,
   input wire logic                grst,
   temporal_pulse_encoder_if.slave bus
);

   localparam int c_VAL_W  = $clog2(GAMMA_CYCLE_WIDTH) + 1;
   localparam int c_TICK_W = $clog2(GAMMA_CYCLE_WIDTH);
   localparam logic [c_TICK_W-1:0] c_LAST = c_TICK_W'(GAMMA_CYCLE_WIDTH - 1);

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [c_TICK_W-1:0]          r_tick;
   logic [c_TICK_W-1:0]          w_tick_nxt;
   logic [NUM_LANES*c_VAL_W-1:0] r_times;
   logic [NUM_LANES*c_VAL_W-1:0] w_times_nxt;
   logic                         r_in_ready;
   logic                         r_busy;
   logic                         r_gamma_start;
   logic                         r_gamma_done;
   logic                         w_xfer;
   logic                         w_last;
   logic                         w_run_nxt;
   logic [NUM_LANES-1:0]         w_q;

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_times_nxt = r_times;
      w_xfer      = bus.in_valid && r_in_ready;
      w_last      = (r_state == RUN) && (r_tick == c_LAST);
      case (r_state)
         IDLE: begin
            if (w_xfer) begin
               w_state_nxt = RUN;
               w_tick_nxt  = '0;
               w_times_nxt = bus.in_times;
            end
         end
         RUN: begin
            if (!w_last) begin
               w_tick_nxt = r_tick + c_TICK_W'(1);
            end else if (w_xfer) begin
               w_tick_nxt  = '0;
               w_times_nxt = bus.in_times;
            end else begin
               w_state_nxt = IDLE;
               w_tick_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_tick_nxt  = '0;
         end
      endcase
   end

   assign w_run_nxt = (w_state_nxt == RUN);

   // Status outputs are decoded from the next state so they line up with q.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         r_state       <= IDLE;
         r_tick        <= '0;
         r_times       <= '0;
         r_in_ready    <= 1'b1;
         r_busy        <= 1'b0;
         r_gamma_start <= 1'b0;
         r_gamma_done  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_tick        <= w_tick_nxt;
         r_times       <= w_times_nxt;
         r_in_ready    <= !w_run_nxt || (w_tick_nxt == c_LAST);
         r_busy        <= w_run_nxt;
         r_gamma_start <= w_run_nxt && (w_tick_nxt == '0);
         r_gamma_done  <= w_run_nxt && (w_tick_nxt == c_LAST);
      end
   end

   generate
      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
         temporal_lane_pulse #(
            .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH       (PULSE_WIDTH),
            .VAL_W             (c_VAL_W),
            .TICK_W            (c_TICK_W)
         ) u_lane (
            .aclk       (aclk),
            .grst       (grst),
            .active_nxt (w_run_nxt),
            .tick_nxt   (w_tick_nxt),
            .t          (w_times_nxt[i*c_VAL_W +: c_VAL_W]),
            .q          (w_q[i])
         );
      end
   endgenerate

   assign bus.in_ready    = r_in_ready;
   assign bus.busy        = r_busy;
   assign bus.gamma_start = r_gamma_start;
   assign bus.gamma_done  = r_gamma_done;
   assign bus.q           = w_q;

endmodule
`default_nettype wire

// File: tb/tb_temporal_pulse_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_temporal_pulse_encoder
// Purpose  : Directed scoreboard bench for the temporal pulse encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temporal_pulse_encoder;
   import stc_pkg::*;

   localparam int G  = 16;
   localparam int PW = 8;
   localparam int NL = 4;
   localparam int VW = 5;

   typedef struct packed {
      logic [NL-1:0] q;
      logic          gs;
      logic          gd;
      logic          busy;
      logic          rdy;
   } exp_t;

   logic aclk = 1'b0;
   logic grst = 1'b1;

   temporal_pulse_encoder_if #(.NUM_LANES(NL), .VAL_W(VW)) bus ();

   temporal_pulse_encoder #(
      .GAMMA_CYCLE_WIDTH (G),
      .PULSE_WIDTH       (PW),
      .NUM_LANES         (NL)
   ) dut (
      .aclk (aclk),
      .grst (grst),
      .bus  (bus)
   );

   always #5 aclk = ~aclk;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   m_run;
   bit   m_rdy;
   int   m_tick;
   int   m_times[NL];
   int   hi_cnt[NL];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
      total++;
      assert (obs === ex) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
      end
   endtask

   function automatic logic [NL*VW-1:0] pack(input int a, input int b, input int c, input int d);
      return {VW'(d), VW'(c), VW'(b), VW'(a)};
   endfunction

   function automatic logic lane_exp(input int t, input int tick);
      int stop;
      if (is_inf(time_t'(t)) || t >= G) return 1'b0;
      stop = (t + PW > G) ? G : t + PW;
      return (tick >= t) && (tick < stop);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      for (int i = 0; i < NL; i++) e.q[i] = m_run && lane_exp(m_times[i], m_tick);
      e.gs   = m_run && (m_tick == 0);
      e.gd   = m_run && (m_tick == G - 1);
      e.busy = m_run;
      e.rdy  = m_rdy;
      return e;
   endfunction

   task automatic model_reset();
      m_run  = 1'b0;
      m_rdy  = 1'b1;
      m_tick = 0;
      for (int i = 0; i < NL; i++) m_times[i] = 0;
   endtask

   task automatic model_step(input logic v, input logic [NL*VW-1:0] tv);
      bit xfer;
      xfer = v && m_rdy;
      if (m_run && m_tick < G - 1) begin
         m_tick++;
      end else if (xfer) begin
         m_run  = 1'b1;
         m_tick = 0;
         for (int i = 0; i < NL; i++) m_times[i] = int'(tv[i*VW +: VW]);
      end else begin
         m_run  = 1'b0;
         m_tick = 0;
      end
      m_rdy = !m_run || (m_tick == G - 1);
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < NL; i++) hi_cnt[i] = 0;
   endtask

   task automatic cyc(input logic v, input logic [NL*VW-1:0] tv);
      exp_t e;
      bus.in_valid = v;
      bus.in_times = tv;
      model_step(v, tv);
      exp_q.push_back(model_out());
      @(posedge aclk);
      #1;
      e = exp_q.pop_front();
      chk("q",           32'(bus.q),           32'(e.q));
      chk("gamma_start", 32'(bus.gamma_start), 32'(e.gs));
      chk("gamma_done",  32'(bus.gamma_done),  32'(e.gd));
      chk("busy",        32'(bus.busy),        32'(e.busy));
      chk("in_ready",    32'(bus.in_ready),    32'(e.rdy));
      for (int i = 0; i < NL; i++) hi_cnt[i] += int'(bus.q[i]);
   endtask

   initial begin
      logic [NL*VW-1:0] v1, v2, v3, v4;
      v1 = pack(0, 3, 8, 16);
      v3 = pack(12, 15, 16, 31);
      v2 = pack(0, 0, 20, 16);
      v4 = pack(1, 9, 14, 2);
      model_reset();
      clr_cnt();
      bus.in_valid = 1'b0;
      bus.in_times = '0;

      #12;
      chk("rst_q",        32'(bus.q),           32'h0);
      chk("rst_busy",     32'(bus.busy),        32'h0);
      chk("rst_gs",       32'(bus.gamma_start), 32'h0);
      chk("rst_gd",       32'(bus.gamma_done),  32'h0);
      chk("rst_in_ready", 32'(bus.in_ready),    32'h1);
      grst = 1'b0;

      repeat (4) cyc(1'b0, v1);

      // Full gamma with mixed start times and one INF lane
      clr_cnt();
      cyc(1'b1, v1);
      chk("t2_gs_tick0", 32'(bus.gamma_start), 32'h1);
      repeat (15) cyc(1'b0, '0);
      chk("t2_gd_tick15", 32'(bus.gamma_done), 32'h1);
      chk("t2_cnt0", 32'(hi_cnt[0]), 32'd8);
      chk("t2_cnt1", 32'(hi_cnt[1]), 32'd8);
      chk("t2_cnt2", 32'(hi_cnt[2]), 32'd8);
      chk("t2_cnt3", 32'(hi_cnt[3]), 32'd0);
      cyc(1'b0, '0);

      // Truncated and silent lanes, next vector held waiting
      clr_cnt();
      cyc(1'b1, v3);
      repeat (15) cyc(1'b1, v2);
      chk("t3_cnt0", 32'(hi_cnt[0]), 32'd4);
      chk("t3_cnt1", 32'(hi_cnt[1]), 32'd1);
      chk("t3_cnt2", 32'(hi_cnt[2]), 32'd0);
      chk("t3_cnt3", 32'(hi_cnt[3]), 32'd0);
      chk("t3_lane1_tick15", 32'(bus.q[1]), 32'h1);
      chk("t4_ready_last", 32'(bus.in_ready), 32'h1);

      // Back-to-back acceptance
      clr_cnt();
      cyc(1'b1, v2);
      chk("t4_gs_nogap",   32'(bus.gamma_start), 32'h1);
      chk("t4_lane1_held", 32'(bus.q[1]),        32'h1);
      repeat (15) cyc(1'b0, '0);
      chk("t4_cnt0", 32'(hi_cnt[0]), 32'd8);
      chk("t4_cnt1", 32'(hi_cnt[1]), 32'd8);
      chk("t4_cnt2", 32'(hi_cnt[2]), 32'd0);

      // No transfer on the last tick returns to idle
      cyc(1'b0, v4);
      chk("t5_busy", 32'(bus.busy),     32'h0);
      chk("t5_q",    32'(bus.q),        32'h0);
      chk("t5_rdy",  32'(bus.in_ready), 32'h1);
      cyc(1'b0, v4);
      cyc(1'b1, v4);
      repeat (17) cyc(1'b0, v1);

      // Asynchronous reset in the middle of a gamma
      cyc(1'b1, v1);
      repeat (5) cyc(1'b0, '0);
      chk("t6_lane1_tick5", 32'(bus.q[1]), 32'h1);
      grst = 1'b1;
      #1;
      chk("t6_q",    32'(bus.q),           32'h0);
      chk("t6_busy", 32'(bus.busy),        32'h0);
      chk("t6_gs",   32'(bus.gamma_start), 32'h0);
      chk("t6_rdy",  32'(bus.in_ready),    32'h1);
      model_reset();
      @(posedge aclk);
      #2;
      grst = 1'b0;
      repeat (20) cyc(1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
